// File: rtl/posit_stream_checker.sv
// posit_stream_checker: on-chip result monitor for posit arithmetic units.
// Golden beats enter a LATENCY-deep delay line and meet the DUT results that
// emerge LATENCY cycles later; every compared lane feeds saturating run
// statistics (samples, errors, max abs diff, first failure location).
//
// Stream semantics: there is no back-pressure. exp_valid marks a golden beat
// in the cycle its operands enter the DUT; it is accepted only in RUN, and
// dut_data is assumed valid exactly LATENCY cycles after each accepted beat.
module posit_stream_checker #(
  parameter int N       = 8,
  parameter int LATENCY = 3,
  parameter int LANES   = 1,
  parameter int TOL     = 0,
  parameter int CNT_W   = 32,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 exp_valid,
  input  logic [LANES*N-1:0]   exp_data,
  input  logic [LANES*N-1:0]   dut_data,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     error_count,
  output logic [N-1:0]         max_diff,
  output logic [CNT_W-1:0]     first_err_index,
  output logic [LANE_W-1:0]    first_err_lane,
  output logic                 err_seen,
  output logic [1:0]           dbg_state
);

  localparam int DW = $clog2(LATENCY + 1);
  localparam int SW = CNT_W + 6;
  localparam logic [N-1:0] TOL_N = N'(TOL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic                clear;

  logic [LATENCY-1:0]  dl_valid_q;
  logic [LANES*N-1:0]  dl_data_q [LATENCY];

  logic                cmp_v;
  logic                any_fail;
  logic [5:0]          nfail;
  logic [LANE_W-1:0]   low_lane;
  logic [N-1:0]        beat_max;
  logic [N-1:0]        lane_exp, lane_dut, lane_diff;

  logic                mismatch_q, seen_q;
  logic [CNT_W-1:0]    sample_q, error_q, beat_q, fidx_q;
  logic [N-1:0]        max_q;
  logic [LANE_W-1:0]   flane_q;

  logic [SW-1:0]       smp_sum, err_sum;
  logic [CNT_W-1:0]    sample_sat, error_sat, beat_inc;

  // FSM state and drain counter register
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // FSM next state; clear fires on every entry into RUN from IDLE or DONE
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        clear   = 1'b1;
      end
      S_RUN: if (stop) begin
        state_d = S_DRAIN;
        drain_d = DW'(LATENCY);
      end
      S_DRAIN: begin
        drain_d = drain_q - DW'(1);
        if (drain_q <= DW'(1)) begin
          state_d = S_DONE;
          drain_d = '0;
        end
      end
      S_DONE: if (start) begin
        state_d = S_RUN;
        clear   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delay line valid bits: only RUN admits new beats, shifting never pauses
  always_ff @(posedge aclk) begin
    if (reset || clear) begin
      dl_valid_q <= '0;
    end else begin
      dl_valid_q[0] <= exp_valid && (state_q == S_RUN);
      for (int i = LATENCY - 1; i > 0; i--) dl_valid_q[i] <= dl_valid_q[i-1];
    end
  end

  // Delay line payload; qualified by the valid bits so it needs no reset
  always_ff @(posedge aclk) begin
    dl_data_q[0] <= exp_data;
    for (int i = LATENCY - 1; i > 0; i--) dl_data_q[i] <= dl_data_q[i-1];
  end

  assign cmp_v = dl_valid_q[LATENCY-1];

  // Per-lane absolute difference of raw patterns, fail count, lowest failing lane
  always_comb begin
    any_fail  = 1'b0;
    nfail     = '0;
    low_lane  = '0;
    beat_max  = '0;
    lane_exp  = '0;
    lane_dut  = '0;
    lane_diff = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_exp  = dl_data_q[LATENCY-1][k*N +: N];
      lane_dut  = dut_data[k*N +: N];
      lane_diff = (lane_exp >= lane_dut) ? (lane_exp - lane_dut) : (lane_dut - lane_exp);
      if (lane_diff > beat_max) beat_max = lane_diff;
      if (lane_diff > TOL_N) begin
        if (!any_fail) low_lane = LANE_W'(k);
        any_fail = 1'b1;
        nfail    = nfail + 6'd1;
      end
    end
  end

  assign smp_sum    = {6'b0, sample_q} + SW'(LANES);
  assign err_sum    = {6'b0, error_q} + {{CNT_W{1'b0}}, nfail};
  assign sample_sat = (|smp_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : smp_sum[CNT_W-1:0];
  assign error_sat  = (|err_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
  assign beat_inc   = (&beat_q) ? beat_q : beat_q + CNT_W'(1);

  // Run statistics: cleared at run start, updated once per compared beat
  always_ff @(posedge aclk) begin
    if (reset || clear) begin
      mismatch_q <= 1'b0;
      seen_q     <= 1'b0;
      sample_q   <= '0;
      error_q    <= '0;
      beat_q     <= '0;
      fidx_q     <= '0;
      max_q      <= '0;
      flane_q    <= '0;
    end else begin
      mismatch_q <= cmp_v && any_fail;
      if (cmp_v) begin
        sample_q <= sample_sat;
        error_q  <= error_sat;
        beat_q   <= beat_inc;
        if (beat_max > max_q) max_q <= beat_max;
        if (any_fail && !seen_q) begin
          seen_q  <= 1'b1;
          fidx_q  <= beat_q;
          flane_q <= low_lane;
        end
      end
    end
  end

  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign mismatch        = mismatch_q;
  assign sample_count    = sample_q;
  assign error_count     = error_q;
  assign max_diff        = max_q;
  assign first_err_index = fidx_q;
  assign first_err_lane  = flane_q;
  assign err_seen        = seen_q;
  assign dbg_state       = state_q;

endmodule
